// File: rtl/readout_arbiter.sv
// Round-robin readout of block FIFOs: grants one block, deserialises its 36-bit
// LSB-first word, and presents it on a valid/ready output.
module readout_arbiter #(
   parameter int NUM_BLOCKS = 8,
   parameter int SRC_W      = 3
) (
   input  logic                  fifo_clk,
   input  logic                  fifo_rst,
   input  logic                  enable,
   input  logic [NUM_BLOCKS-1:0] fifo_empty,
   input  logic [NUM_BLOCKS-1:0] fifo_oflow,
   input  logic [NUM_BLOCKS-1:0] fifo_bit,
   output logic [NUM_BLOCKS-1:0] fifo_req,
   output logic [35:0]           word_data,
   output logic [SRC_W-1:0]      word_src,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [NUM_BLOCKS-1:0] oflow_sticky,
   input  logic                  clear_oflow,
   output logic                  busy
);

   typedef enum logic [2:0] {S_SCAN, S_REQ, S_SHIFT, S_OUT, S_GUARD} state_t;

   localparam logic [SRC_W:0] NB = (SRC_W+1)'(NUM_BLOCKS);

   state_t                state_q, state_d;
   logic [SRC_W-1:0]      sel_q, sel_d;
   logic [SRC_W-1:0]      ptr_q, ptr_d;
   logic [5:0]            cnt_q, cnt_d;
   logic                  guard_q, guard_d;
   logic                  armed_q;
   logic [NUM_BLOCKS-1:0] req_q, req_d;
   logic [35:0]           word_q, word_d;
   logic [NUM_BLOCKS-1:0] oflow_q;

   logic [SRC_W:0]        shamt;
   logic [NUM_BLOCKS-1:0] rot;
   logic [SRC_W-1:0]      off;
   logic [SRC_W:0]        sum;
   logic [SRC_W-1:0]      pick;
   logic                  any_pend;

   // Rotate the non-empty mask so bit 0 is block ptr+1; the lowest set bit wins.
   always_comb begin
      shamt = {1'b0, ptr_q} + (SRC_W+1)'(1);
      rot   = NUM_BLOCKS'({~fifo_empty, ~fifo_empty} >> shamt);
      off   = '0;
      for (int j = NUM_BLOCKS-1; j >= 0; j--) begin
         if (rot[j]) off = SRC_W'(j);
      end
      sum = shamt + {1'b0, off};
      if (sum >= NB) sum = sum - NB;
      pick     = sum[SRC_W-1:0];
      any_pend = |rot;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      guard_d = guard_q;
      req_d   = '0;
      word_d  = word_q;
      case (state_q)
         S_SCAN: begin
            if (armed_q && enable && any_pend) begin
               state_d = S_REQ;
               sel_d   = pick;
               req_d   = NUM_BLOCKS'(1) << pick;
            end
         end
         S_REQ: begin
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            word_d = {fifo_bit[sel_q], word_q[35:1]};
            cnt_d  = cnt_q + 6'd1;
            if (cnt_q == 6'd35) state_d = S_OUT;
         end
         S_OUT: begin
            if (word_ready) begin
               ptr_d   = sel_q;
               guard_d = 1'b0;
               state_d = S_GUARD;
            end
         end
         S_GUARD: begin
            // The second guard cycle doubles as the scan decision, giving a 40-cycle word period.
            if (!guard_q) begin
               guard_d = 1'b1;
            end else if (enable && any_pend) begin
               state_d = S_REQ;
               sel_d   = pick;
               req_d   = NUM_BLOCKS'(1) << pick;
            end else begin
               state_d = S_SCAN;
            end
         end
         default: state_d = S_SCAN;
      endcase
   end

   always_ff @(posedge fifo_clk or posedge fifo_rst) begin
      if (fifo_rst) begin
         state_q <= S_SCAN;
         sel_q   <= '0;
         ptr_q   <= SRC_W'(NUM_BLOCKS-1);
         cnt_q   <= '0;
         guard_q <= 1'b0;
         armed_q <= 1'b0;
         req_q   <= '0;
         word_q  <= '0;
         oflow_q <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         guard_q <= guard_d;
         armed_q <= 1'b1;
         req_q   <= req_d;
         word_q  <= word_d;
         oflow_q <= (oflow_q & ~{NUM_BLOCKS{clear_oflow}}) | fifo_oflow;
      end
   end

   assign fifo_req     = req_q;
   assign word_data    = word_q;
   assign word_src     = sel_q;
   assign word_valid   = (state_q == S_OUT);
   assign oflow_sticky = oflow_q;
   assign busy         = (state_q != S_SCAN);

endmodule

// File: tb/tb_readout_arbiter.sv
// Bench for readout_arbiter: behavioural FWFT block FIFOs, a grant-time scoreboard,
// a table of round-robin transfers and hand-written corner sequences.
module tb_readout_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  fifo_empty;
   logic [7:0]  fifo_oflow;
   logic [7:0]  fifo_bit;
   logic [7:0]  fifo_req;
   logic [35:0] word_data;
   logic [2:0]  word_src;
   logic        word_valid;
   logic        word_ready;
   logic [7:0]  oflow_sticky;
   logic        clear_oflow;
   logic        busy;

   readout_arbiter #(.NUM_BLOCKS(8), .SRC_W(3)) dut (
      .fifo_clk(clk), .fifo_rst(rst), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_oflow(fifo_oflow), .fifo_bit(fifo_bit),
      .fifo_req(fifo_req), .word_data(word_data), .word_src(word_src),
      .word_valid(word_valid), .word_ready(word_ready),
      .oflow_sticky(oflow_sticky), .clear_oflow(clear_oflow), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [35:0] word_of(input int i);
      if (i == 2) return 36'h9ABCD1234;
      return 36'hC3E5A0F0F ^ (36'(i) * 36'h111111111);
   endfunction

   function automatic int oh2idx(input logic [7:0] v);
      int r = 0;
      for (int i = 0; i < 8; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Block FIFO model: load on grant, then present one bit per cycle, LSB first.
   logic [35:0] sh [8];
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (fifo_req[i]) sh[i] <= word_of(i);
         else             sh[i] <= sh[i] >> 1;
      end
   end
   always_comb begin
      fifo_bit = '0;
      for (int i = 0; i < 8; i++) fifo_bit[i] = sh[i][0];
   end

   int          cyc = 0;
   int          last_req_cyc = 0;
   int          prev_req_cyc = 0;
   int          onehot_err = 0;
   logic [39:0] sb [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (fifo_req != 8'h00) begin
         sb.push_back({4'(oh2idx(fifo_req)), word_of(oh2idx(fifo_req))});
         prev_req_cyc <= last_req_cyc;
         last_req_cyc <= cyc;
      end
      if ($countones(fifo_req) > 1) onehot_err <= onehot_err + 1;
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait for a handshake, check it, then step past the accepting edge.
   task automatic get_word(input int exp_src, input bit chk_lat, input bit chk_gap);
      int          waited = 0;
      bit          seen = 1'b0;
      int          vcyc = 0;
      logic [39:0] e;
      while (!(word_valid && word_ready) && waited < 300) begin
         if (word_valid && !seen) begin seen = 1'b1; vcyc = cyc; end
         @(negedge clk);
         waited++;
      end
      if (!seen) vcyc = cyc;
      if (waited >= 300) begin
         chk("word_timeout", 64'(waited), 64'(0));
         return;
      end
      chk("word_src", 64'(word_src), 64'(exp_src));
      chk("word_data", 64'(word_data), 64'(word_of(exp_src)));
      if (sb.size() == 0) begin
         chk("sb_empty", 64'(1), 64'(0));
      end else begin
         e = sb.pop_front();
         chk("sb_data", 64'(word_data), 64'(e[35:0]));
         chk("sb_src", 64'(word_src), 64'(e[39:36]));
      end
      if (chk_lat) chk("latency", 64'(vcyc - last_req_cyc), 64'(37));
      if (chk_gap) chk("req_period", 64'(last_req_cyc - prev_req_cyc), 64'(40));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int b);
      int w = 0;
      while (!fifo_req[b] && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("wait_req", 64'(fifo_req[b]), 64'(1));
   endtask

   typedef struct {
      logic [7:0] mask;
      int         exp_src;
      bit         chk_gap;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int bad;
      logic [35:0] hold_data;

      tbl[0]  = '{8'h89, 0, 1'b0};
      tbl[1]  = '{8'h89, 3, 1'b1};
      tbl[2]  = '{8'h89, 7, 1'b1};
      tbl[3]  = '{8'h89, 0, 1'b1};
      tbl[4]  = '{8'h89, 3, 1'b1};
      tbl[5]  = '{8'h89, 7, 1'b1};
      tbl[6]  = '{8'h04, 2, 1'b1};
      tbl[7]  = '{8'hFF, 3, 1'b1};
      tbl[8]  = '{8'h01, 0, 1'b1};
      tbl[9]  = '{8'h80, 7, 1'b1};
      tbl[10] = '{8'h81, 0, 1'b1};
      tbl[11] = '{8'h30, 4, 1'b1};

      rst = 1'b1; enable = 1'b1; fifo_empty = ~tbl[0].mask;
      fifo_oflow = '0; clear_oflow = 1'b0; word_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(word_valid), 64'(0));
      chk("rst_data", 64'(word_data), 64'(0));
      chk("rst_src", 64'(word_src), 64'(0));
      chk("rst_req", 64'(fifo_req), 64'(0));
      chk("rst_sticky", 64'(oflow_sticky), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));

      rst = 1'b0;
      @(negedge clk);
      chk("first_edge_req", 64'(fifo_req), 64'(0));
      @(negedge clk);
      chk("second_edge_req", 64'(fifo_req), 64'(8'h01));

      for (int k = 0; k < 12; k++) begin
         fifo_empty = ~tbl[k].mask;
         get_word(tbl[k].exp_src, 1'b1, tbl[k].chk_gap);
      end

      // Consumer stalls for 10 cycles in OUT.
      word_ready = 1'b0;
      fifo_empty = ~8'h02;
      begin
         int w = 0;
         while (!word_valid && w < 100) begin @(negedge clk); w++; end
      end
      hold_data = word_of(1);
      bad = 0;
      repeat (10) begin
         @(negedge clk);
         if (!word_valid || word_data !== hold_data || word_src !== 3'd1 || fifo_req !== 8'h00) bad++;
      end
      chk("stall_hold", 64'(bad), 64'(0));
      word_ready = 1'b1;
      get_word(1, 1'b0, 1'b0);
      @(negedge clk);
      chk("guard1_req", 64'(fifo_req), 64'(0));
      @(negedge clk);
      chk("guard2_req", 64'(fifo_req), 64'(0));
      @(negedge clk);
      chk("post_guard_req", 64'(fifo_req), 64'(8'h02));
      fifo_empty = 8'hFF;
      get_word(1, 1'b1, 1'b0);

      // Enable drops while block 5 is shifting.
      fifo_empty = ~8'h20;
      wait_req(5);
      repeat (5) @(negedge clk);
      enable = 1'b0;
      get_word(5, 1'b1, 1'b0);
      bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (fifo_req != 8'h00) bad++;
      end
      chk("no_req_enable_low", 64'(bad), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      fifo_empty = 8'hFF;
      enable = 1'b1;

      // Overflow set coinciding with clear: set wins; a lone clear then clears.
      @(negedge clk);
      fifo_oflow = 8'h10; clear_oflow = 1'b1;
      @(negedge clk);
      fifo_oflow = 8'h00; clear_oflow = 1'b0;
      chk("oflow_set_wins", 64'(oflow_sticky), 64'(8'h10));
      @(negedge clk);
      clear_oflow = 1'b1;
      @(negedge clk);
      clear_oflow = 1'b0;
      chk("oflow_cleared", 64'(oflow_sticky), 64'(0));

      // Reset during shift bit 20 of block 3.
      fifo_empty = ~8'h08;
      wait_req(3);
      repeat (21) @(negedge clk);
      chk("busy_mid_shift", 64'(busy), 64'(1));
      rst = 1'b1;
      #1;
      chk("arst_valid", 64'(word_valid), 64'(0));
      chk("arst_data", 64'(word_data), 64'(0));
      chk("arst_src", 64'(word_src), 64'(0));
      chk("arst_req", 64'(fifo_req), 64'(0));
      chk("arst_busy", 64'(busy), 64'(0));
      sb.delete();
      fifo_empty = ~8'h09;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_edge1_req", 64'(fifo_req), 64'(0));
      chk("rel_no_valid", 64'(word_valid), 64'(0));
      @(negedge clk);
      chk("rel_edge2_req", 64'(fifo_req), 64'(8'h01));
      fifo_empty = 8'hFF;
      get_word(0, 1'b1, 1'b0);

      chk("req_onehot", 64'(onehot_err), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
